// File: rtl/pattern_writer_pkg.sv
// pattern_writer_pkg: state encoding shared by the pattern store write side
package pattern_writer_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, COMMIT = 2'd2} state_t;
endpackage

// File: rtl/pattern_ram.sv
// pattern_ram: DEPTH x WIDTH image store, sync write (we/wa/wd), async read (ra/rd, zero when out of range)
module pattern_ram #(
  parameter int WIDTH = 1600,
  parameter int DEPTH = 9
)(
  input  logic             clk,
  input  logic             we,
  input  logic [7:0]       wa,
  input  logic [WIDTH-1:0] wd,
  input  logic [7:0]       ra,
  output logic [WIDTH-1:0] rd
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] r_mem [DEPTH];
  always_ff @(posedge clk)
    if (we && wa < 8'(DEPTH)) r_mem[wa[AW-1:0]] <= wd;
  assign rd = ra < 8'(DEPTH) ? r_mem[ra[AW-1:0]] : '0;
endmodule

// File: rtl/pattern_writer.sv
// pattern_writer: streams one image into a shift buffer and commits it to a pattern slot in one cycle
//   start/wr_slot/abort: load control; s_valid/s_data/s_ready: pixel stream
//   busy/done/err: status; pattern_valid: committed-slot map; a/image: async slot read
module pattern_writer
  import pattern_writer_pkg::*;
#(
  parameter int MEM_WIDTH   = 16,
  parameter int IMAGE_WIDTH = 10,
  parameter int MAX_SIZE    = 9
)(
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       start,
  input  logic [7:0]                                 wr_slot,
  input  logic                                       abort,
  input  logic                                       s_valid,
  input  logic [MEM_WIDTH-1:0]                       s_data,
  output logic                                       s_ready,
  output logic                                       busy,
  output logic                                       done,
  output logic                                       err,
  output logic [MAX_SIZE-1:0]                        pattern_valid,
  input  logic [7:0]                                 a,
  output logic [MEM_WIDTH*IMAGE_WIDTH*IMAGE_WIDTH-1:0] image
);
  localparam int N  = IMAGE_WIDTH * IMAGE_WIDTH;
  localparam int IB = MEM_WIDTH * N;
  localparam int CW = $clog2(N + 1);
  state_t          r_state, w_next;
  logic [CW-1:0]   r_cnt;
  logic [7:0]      r_slot;
  logic [IB-1:0]   r_buf;
  logic [MAX_SIZE-1:0] r_valid;
  logic            r_err;
  logic            w_ok, w_beat, w_last;
  assign w_ok   = start && wr_slot < 8'(MAX_SIZE);
  // abort wins over a beat presented in the same cycle
  assign w_beat = r_state == LOAD && s_valid && !abort;
  assign w_last = w_beat && r_cnt == CW'(N - 1);
  always_comb begin
    w_next  = r_state;
    s_ready = r_state == LOAD;
    busy    = r_state != IDLE;
    done    = r_state == COMMIT;
    err     = r_err;
    case (r_state)
      IDLE:    w_next = w_ok ? LOAD : IDLE;
      LOAD:    w_next = abort ? IDLE : w_last ? COMMIT : LOAD;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_slot  <= '0;
      r_err   <= 1'b0;
      r_valid <= '0;
    end else begin
      r_state <= w_next;
      r_err   <= r_state == IDLE && start && !w_ok;
      if (r_state == IDLE && w_ok) begin
        r_slot <= wr_slot;
        r_cnt  <= '0;
      end else if (w_beat) r_cnt <= r_cnt + 1'b1;
      if (r_state == COMMIT) r_valid <= r_valid | (MAX_SIZE'(1) << r_slot);
    end
  // new words enter at the top so the first word ends up at the LSBs
  always_ff @(posedge clk)
    if (w_beat) r_buf <= {s_data, r_buf[IB-1:MEM_WIDTH]};
  assign pattern_valid = r_valid;
  pattern_ram #(.WIDTH(IB), .DEPTH(MAX_SIZE)) u_ram (
    .clk (clk),
    .we  (r_state == COMMIT),
    .wa  (r_slot),
    .wd  (r_buf),
    .ra  (a),
    .rd  (image)
  );
endmodule

// File: tb/tb_pattern_writer.sv
// tb_pattern_writer: randomized and directed checks of pattern_writer against a slot-level model
module tb_pattern_writer;
  localparam int MW = 4, IW = 2, MS = 9, N = IW * IW, IB = MW * N;
  logic clk = 0, rst = 1, start = 0, abort = 0, s_valid = 0;
  logic [7:0] wr_slot = 0, a = 0;
  logic [MW-1:0] s_data = 0;
  logic s_ready, busy, done, err;
  logic [MS-1:0] pattern_valid;
  logic [IB-1:0] image;
  logic [IB-1:0] m_mem [MS];
  bit m_known [MS];
  logic [MS-1:0] m_valid;
  int checks = 0, errs = 0;

  pattern_writer #(.MEM_WIDTH(MW), .IMAGE_WIDTH(IW), .MAX_SIZE(MS)) dut (
    .clk(clk), .rst(rst), .start(start), .wr_slot(wr_slot), .abort(abort),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready), .busy(busy),
    .done(done), .err(err), .pattern_valid(pattern_valid), .a(a), .image(image)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic read_check(input string tag, input int slot);
    a = 8'(slot);
    #1;
    if (slot >= MS) check(tag, 32'(image), 0);
    else if (m_known[slot]) check(tag, 32'(image), 32'(m_mem[slot]));
  endtask

  // words: k-th word in bits [k*MW +: MW]; abort_at<0 means run to completion
  task automatic do_load(input int slot, input logic [IB-1:0] words, input int abort_at,
                         input int gmin, input int gmax, input bit noise);
    logic [IB-1:0] img;
    start = 1;
    wr_slot = 8'(slot);
    step();
    start = 0;
    if (slot >= MS) begin
      check("err_pulse", 32'(err), 1);
      check("err_busy", 32'(busy), 0);
      check("err_pv", 32'(pattern_valid), 32'(m_valid));
      step();
      check("err_clear", 32'(err), 0);
      return;
    end
    check("load_busy", 32'(busy), 1);
    check("load_ready", 32'(s_ready), 1);
    for (int k = 0; k < N; k++) begin
      if (k > 0) begin
        int g = $urandom_range(gmax, gmin);
        for (int j = 0; j < g; j++) begin
          s_valid = 0;
          start = noise && $urandom_range(1, 0) == 1;
          wr_slot = 8'($urandom_range(11, 0));
          step();
          start = 0;
          check("gap_ready", 32'(s_ready), 1);
          check("gap_busy", 32'(busy), 1);
          check("gap_err", 32'(err), 0);
        end
      end
      s_valid = 1;
      s_data = words[k*MW +: MW];
      if (k == abort_at) begin
        abort = 1;
        step();
        abort = 0;
        s_valid = 0;
        check("abort_busy", 32'(busy), 0);
        check("abort_done", 32'(done), 0);
        step();
        check("abort_done2", 32'(done), 0);
        check("abort_pv", 32'(pattern_valid), 32'(m_valid));
        read_check("abort_img", slot);
        return;
      end
      step();
    end
    // s_valid stays high through COMMIT and one IDLE cycle: nothing may be consumed
    check("commit_done", 32'(done), 1);
    check("commit_ready", 32'(s_ready), 0);
    check("commit_busy", 32'(busy), 1);
    abort = noise;
    read_check("commit_old", slot);
    step();
    abort = 0;
    img = '0;
    for (int k = 0; k < N; k++) img |= IB'(words[k*MW +: MW]) << (k * MW);
    m_mem[slot] = img;
    m_known[slot] = 1;
    m_valid[slot] = 1'b1;
    check("post_done", 32'(done), 0);
    check("post_busy", 32'(busy), 0);
    check("post_ready", 32'(s_ready), 0);
    check("post_pv", 32'(pattern_valid), 32'(m_valid));
    read_check("post_img", slot);
    s_valid = 0;
  endtask

  initial begin
    m_valid = '0;
    for (int i = 0; i < MS; i++) m_known[i] = 0;
    #12;
    check("rst_ready", 32'(s_ready), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_err", 32'(err), 0);
    check("rst_pv", 32'(pattern_valid), 0);
    rst = 0;
    step();
    do_load(3, 16'h4321, -1, 0, 0, 0);
    check("t1_img", 32'(image), 32'h4321);
    check("t1_pv", 32'(pattern_valid), 32'h008);
    do_load(3, 16'h4321, -1, 2, 2, 0);
    check("t2_img", 32'(image), 32'h4321);
    do_load(9, 16'h0, -1, 0, 0, 0);
    do_load(0, 16'h7654, 2, 0, 0, 0);
    check("t4_pv0", 32'(pattern_valid[0]), 0);
    start = 1;
    wr_slot = 1;
    step();
    start = 0;
    for (int k = 0; k < 3; k++) begin
      s_valid = 1;
      s_data = 4'(k + 5);
      step();
    end
    s_valid = 0;
    rst = 1;
    #1;
    m_valid = '0;
    check("t5_ready", 32'(s_ready), 0);
    check("t5_busy", 32'(busy), 0);
    check("t5_done", 32'(done), 0);
    check("t5_err", 32'(err), 0);
    check("t5_pv", 32'(pattern_valid), 0);
    read_check("t5_keep3", 3);
    step();
    rst = 0;
    step();
    check("t5_idle", 32'(done), 0);
    do_load(1, 16'h9E5C, -1, 0, 1, 0);
    do_load(3, 16'hDCBA, -1, 0, 0, 0);
    check("t6_img", 32'(image), 32'hDCBA);
    read_check("t6_oor", 200);
    for (int it = 0; it < 40; it++) begin
      int slot = $urandom_range(11, 0);
      int ab = $urandom_range(3, 0) == 0 ? $urandom_range(N - 1, 0) : -1;
      do_load(slot, IB'($urandom), ab, 0, 2, 1);
    end
    for (int s = 0; s < 12; s++) read_check("final_img", s);
    read_check("final_oor", 255);
    check("final_pv", 32'(pattern_valid), 32'(m_valid));
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
